// File: rtl/gray_seq_pkg.sv
// ---------------------------------------------------------------------------
// gray_seq_pkg
// Shared definitions for the Gray-code sequence controller:
//   DEF_WIDTH - default code width in bits (minimum 2)
//   state_t   - controller states IDLE / RUN / FIN
// ---------------------------------------------------------------------------
package gray_seq_pkg;

    localparam int DEF_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;

endpackage

// File: rtl/gray_seq_ctrl_if.sv
// ---------------------------------------------------------------------------
// gray_seq_ctrl_if
// Request / code-stream bundle of the Gray-code sequence controller.
//   start     : single-cycle request to begin a sequence
//   stop      : abort request while running
//   dir_down  : 0 = count 0..limit, 1 = count limit..0
//   limit     : terminal binary value
//   out_valid : gray_out/bin_out carry a valid code
//   out_ready : consumer accepts the code on out_valid && out_ready
//   gray_out  : registered Gray code
//   bin_out   : registered binary value matching gray_out
//   busy      : sequence in progress (RUN or FIN)
//   done      : one-cycle completion pulse
// Modports: master = requester/consumer side, slave = controller side.
// ---------------------------------------------------------------------------
interface gray_seq_ctrl_if
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
);

    logic             start;
    logic             stop;
    logic             dir_down;
    logic [WIDTH-1:0] limit;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] gray_out;
    logic [WIDTH-1:0] bin_out;
    logic             busy;
    logic             done;

    modport master (
        output start, stop, dir_down, limit, out_ready,
        input  out_valid, gray_out, bin_out, busy, done
    );

    modport slave (
        input  start, stop, dir_down, limit, out_ready,
        output out_valid, gray_out, bin_out, busy, done
    );

endinterface

// File: rtl/gray_encode.sv
// ---------------------------------------------------------------------------
// gray_encode
// Combinational binary-to-Gray conversion: gray = bin ^ (bin >> 1).
//   bin  : binary input, WIDTH bits
//   gray : Gray-coded output, WIDTH bits
// ---------------------------------------------------------------------------
module gray_encode #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] bin,
    output logic [WIDTH-1:0] gray
);

    assign gray = bin ^ (bin >> 1);

endmodule

// File: rtl/gray_seq_ctrl.sv
// ---------------------------------------------------------------------------
// gray_seq_ctrl
// Steps a binary counter from 0 to limit (or limit down to 0) and presents
// each value together with its Gray code over a valid/ready stream. A
// sequence starts on a start pulse in IDLE, advances one code per accepted
// beat, and ends with a one-cycle done pulse in FIN, either after the
// terminal code is accepted or on stop.
//
// Ports:
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset (clears all state and outputs)
//   bus   : gray_seq_ctrl_if.slave (start/stop/dir_down/limit in,
//           out_valid/gray_out/bin_out/busy/done out, out_ready in)
//
// Build option:
//   GRAY_SEQ_WRAP_EN - when defined, accepting the terminal code reloads the
//                      start value and the sequence keeps running until stop.
// ---------------------------------------------------------------------------
module gray_seq_ctrl
    import gray_seq_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH
) (
    input  logic            clk,
    input  logic            rst_n,
    gray_seq_ctrl_if.slave  bus
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] bin_q,   bin_d;
    logic [WIDTH-1:0] gray_q,  gray_d;
    logic [WIDTH-1:0] lim_q,   lim_d;
    logic             dir_q,   dir_d;
    logic             at_term;

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        lim_d   = lim_q;
        dir_d   = dir_q;
        at_term = dir_q ? (bin_q == '0) : (bin_q == lim_q);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = RUN;
                    lim_d   = bus.limit;
                    dir_d   = bus.dir_down;
                    bin_d   = bus.dir_down ? bus.limit : '0;
                end
            end
            RUN: begin
                // stop wins over advancing; the code on the bus this cycle is
                // still consumed by the sink if it is ready.
                if (bus.stop) begin
                    state_d = FIN;
                end else if (bus.out_ready) begin
                    if (at_term) begin
`ifdef GRAY_SEQ_WRAP_EN
                        bin_d = dir_q ? lim_q : '0;
`else
                        state_d = FIN;
`endif
                    end else begin
                        bin_d = dir_q ? (bin_q - 1'b1) : (bin_q + 1'b1);
                    end
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Encoding the next binary value lets gray_out be registered alongside
    // bin_out with no extra cycle of latency.
    gray_encode #(.WIDTH(WIDTH)) u_gray_encode (
        .bin  (bin_d),
        .gray (gray_d)
    );

    // ---- register stage ----
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            bin_q   <= '0;
            gray_q  <= '0;
            lim_q   <= '0;
            dir_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            gray_q  <= gray_d;
            lim_q   <= lim_d;
            dir_q   <= dir_d;
        end
    end

    assign bus.out_valid = (state_q == RUN);
    assign bus.busy      = (state_q == RUN) || (state_q == FIN);
    assign bus.done      = (state_q == FIN);
    assign bus.gray_out  = gray_q;
    assign bus.bin_out   = bin_q;

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// ---------------------------------------------------------------------------
// tb_gray_seq_ctrl
// Self-checking bench for gray_seq_ctrl (WIDTH=4). Expected codes and done
// markers are queued when a sequence is launched and retired by a monitor
// on every accepted beat and every done pulse.
// ---------------------------------------------------------------------------
module tb_gray_seq_ctrl;
    import gray_seq_pkg::*;

    localparam int W = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    gray_seq_ctrl_if #(.WIDTH(W)) bus ();

    gray_seq_ctrl #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct packed {
        logic         is_done;
        logic [W-1:0] gray;
        logic [W-1:0] bin;
    } sb_item_t;

    sb_item_t sb_q[$];
    sb_item_t mon_it;
    int       err_cnt = 0;
    int       chk_cnt = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

    task automatic push_code(input logic [W-1:0] b, input logic [W-1:0] g);
        sb_q.push_back('{is_done: 1'b0, gray: g, bin: b});
    endtask

    task automatic push_done();
        sb_q.push_back('{is_done: 1'b1, gray: '0, bin: '0});
    endtask

    // Queue n codes starting at first, stepping up or down.
    task automatic push_run(input logic [W-1:0] first, input int n, input logic dn);
        logic [W-1:0] b;
        b = first;
        for (int i = 0; i < n; i++) begin
            push_code(b, to_gray(b));
            b = dn ? b - 1'b1 : b + 1'b1;
        end
    endtask

    // Scoreboard monitor: sample between edges.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.out_valid && bus.out_ready) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow_code", sb_q.size(), 1);
                end else begin
                    mon_it = sb_q.pop_front();
                    check_val("beat_kind", mon_it.is_done, 0);
                    check_val("beat_gray", bus.gray_out, mon_it.gray);
                    check_val("beat_bin", bus.bin_out, mon_it.bin);
                end
            end
            if (bus.done) begin
                if (sb_q.size() == 0) begin
                    check_val("sb_underflow_done", sb_q.size(), 1);
                end else begin
                    mon_it = sb_q.pop_front();
                    check_val("done_kind", mon_it.is_done, 1);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Launch a sequence; inputs are scrambled afterwards so latching is exercised.
    task automatic start_seq(input logic [W-1:0] lim, input logic dn);
        bus.limit    = lim;
        bus.dir_down = dn;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        bus.limit    = ~lim;
        bus.dir_down = ~dn;
        check_val("first_valid", bus.out_valid, 1);
    endtask

    task automatic wait_bin(input string tag, input logic [W-1:0] b, input int budget);
        int n;
        n = 0;
        while (bus.bin_out !== b && n < budget) begin
            tick();
            n++;
        end
        check_val({tag, "_reached"}, bus.bin_out, b);
    endtask

    task automatic wait_done(input string tag, input int budget, output int cycles);
        int n;
        n = 0;
        while (bus.done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        cycles = n;
        check_val({tag, "_done"}, bus.done, 1);
        tick();
        check_val({tag, "_idle_busy"}, bus.busy, 0);
        check_val({tag, "_sb_empty"}, sb_q.size(), 0);
    endtask

    initial begin
        int cyc;
        logic [W-1:0] g030 [8];
        g030 = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110, 4'b0111, 4'b0101, 4'b0100};

        bus.start     = 1'b0;
        bus.stop      = 1'b0;
        bus.dir_down  = 1'b0;
        bus.limit     = '0;
        bus.out_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        check_val("rst_valid", bus.out_valid, 0);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_done", bus.done, 0);
        check_val("rst_gray", bus.gray_out, 0);
        check_val("rst_bin", bus.bin_out, 0);
        rst_n = 1'b1;
        tick();
        bus.out_ready = 1'b1;

        // Up count to 7: literal Gray table, done exactly 8 cycles after first code.
        for (int i = 0; i < 8; i++) push_code(W'(i), g030[i]);
        push_done();
        start_seq(4'd7, 1'b0);
        wait_done("up7", 20, cyc);
        check_val("up7_done_latency", cyc, 8);

        // Down count from 3, with a start pulse mid-run that must be ignored.
        push_code(4'd3, 4'b0010);
        push_code(4'd2, 4'b0011);
        push_code(4'd1, 4'b0001);
        push_code(4'd0, 4'b0000);
        push_done();
        start_seq(4'd3, 1'b1);
        bus.limit = 4'd9;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_done("down3", 20, cyc);

        // limit = 0: exactly one beat in either direction.
        push_code(4'd0, 4'd0);
        push_done();
        start_seq(4'd0, 1'b0);
        wait_done("zero_up", 10, cyc);
        check_val("zero_up_latency", cyc, 1);
        push_code(4'd0, 4'd0);
        push_done();
        start_seq(4'd0, 1'b1);
        wait_done("zero_dn", 10, cyc);
        check_val("zero_dn_latency", cyc, 1);

        // Stall for 3 cycles at bin=2.
        push_run(4'd0, 6, 1'b0);
        push_done();
        start_seq(4'd5, 1'b0);
        wait_bin("stall", 4'd2, 10);
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_val("stall_gray", bus.gray_out, 4'b0011);
            check_val("stall_valid", bus.out_valid, 1);
            tick();
        end
        check_val("stall_gray_end", bus.gray_out, 4'b0011);
        bus.out_ready = 1'b1;
        wait_done("stall", 20, cyc);

        // Stop at bin=4 of a 0..15 run, then restart from 0.
        push_run(4'd0, 5, 1'b0);
        push_done();
        start_seq(4'd15, 1'b0);
        wait_bin("stop", 4'd4, 20);
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_val("stop_valid", bus.out_valid, 0);
        check_val("stop_done", bus.done, 1);
        tick();
        check_val("stop_busy", bus.busy, 0);
        check_val("stop_done_pulse", bus.done, 0);
        check_val("stop_sb_empty", sb_q.size(), 0);
        push_run(4'd0, 3, 1'b0);
        push_done();
        start_seq(4'd2, 1'b0);
        check_val("restart_gray", bus.gray_out, 0);
        wait_done("restart", 10, cyc);

        // Asynchronous reset mid-sequence at bin=6.
        push_run(4'd0, 6, 1'b0);
        start_seq(4'd15, 1'b0);
        wait_bin("rst_mid", 4'd6, 20);
        rst_n = 1'b0;
        #1;
        check_val("rstmid_valid", bus.out_valid, 0);
        check_val("rstmid_busy", bus.busy, 0);
        check_val("rstmid_done", bus.done, 0);
        check_val("rstmid_gray", bus.gray_out, 0);
        check_val("rstmid_bin", bus.bin_out, 0);
        check_val("rstmid_sb_empty", sb_q.size(), 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push_run(4'd0, 2, 1'b0);
        push_done();
        start_seq(4'd1, 1'b0);
        check_val("post_rst_gray", bus.gray_out, 0);
        check_val("post_rst_bin", bus.bin_out, 0);
        wait_done("post_rst", 10, cyc);

`ifdef GRAY_SEQ_WRAP_EN
        // Wrap: 0,1,2,0,1 then stop.
        push_run(4'd0, 3, 1'b0);
        push_run(4'd0, 2, 1'b0);
        push_done();
        start_seq(4'd2, 1'b0);
        for (int i = 0; i < 4; i++) tick();
        bus.stop = 1'b1;
        tick();
        bus.stop = 1'b0;
        check_val("wrap_done", bus.done, 1);
        tick();
        check_val("wrap_sb_empty", sb_q.size(), 0);
`else
        // Single pass to 2 with no wrap.
        push_run(4'd0, 3, 1'b0);
        push_done();
        start_seq(4'd2, 1'b0);
        wait_done("nowrap", 10, cyc);
        check_val("nowrap_latency", cyc, 3);
`endif

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, errors=%0d checks=%0d", err_cnt, chk_cnt);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gray_seq_ctrl.md
GRAY_SEQ_CTRL -- requirements
Module: gray_seq_ctrl

Interface
REQ-001 Parameter WIDTH, default 4: code width in bits, minimum 2.
REQ-002 Port clk  input  1: sole clock, rising edge.
REQ-003 Port rst_n  input  1: reset, asynchronous assert, active-low.
REQ-004 Port start  input  1: single-cycle request to begin a sequence; sampled only in IDLE.
REQ-005 Port stop  input  1: abort request; sampled in RUN.
REQ-006 Port dir_down  input  1: 0 counts up from 0 to limit, 1 counts down from limit to 0; latched at start.
REQ-007 Port limit  input  WIDTH: terminal binary value; latched at start.
REQ-008 Port out_valid  output  1: gray_out/bin_out carry a valid code.
REQ-009 Port out_ready  input  1: consumer accepts the code when out_valid&&out_ready at a rising edge.
REQ-010 Port gray_out  output  WIDTH: registered Gray code, bin^(bin>>1).
REQ-011 Port bin_out  output  WIDTH: registered binary value matching gray_out.
REQ-012 Port busy  output  1: high in RUN and FIN.
REQ-013 Port done  output  1: one-cycle pulse in FIN.

Function
REQ-014 FSM states SHALL be IDLE, RUN and FIN, encoded in a shared enum.
REQ-015 IDLE: start=1 -> RUN next cycle; bin loads 0 (up) or limit (down); out_valid=1 from that cycle.
REQ-016 RUN: beat accepted and bin!=terminal (limit up, 0 down) -> bin +1/-1 next cycle; out_valid stays 1, no bubble.
REQ-017 RUN: beat accepted with bin==terminal -> FIN next cycle, out_valid=0.
REQ-018 RUN with out_ready=0: out_valid, gray_out and bin_out SHALL hold stable.
REQ-019 stop=1 in RUN -> FIN next cycle, out_valid=0; any code presented that cycle is still accepted if out_ready=1.
REQ-020 FIN SHALL last exactly one cycle with done=1, then return to IDLE; start is ignored in RUN and FIN.
REQ-021 limit=0 SHALL yield exactly one beat (code 0) then FIN, in either direction.
REQ-022 Arithmetic SHALL be modulo 2^WIDTH; consecutive accepted gray_out values differ in exactly one bit.
REQ-023 Latency: start edge to first valid code = 1 cycle; last acceptance to done = 1 cycle.

Reset
REQ-024 rst_n=0 SHALL immediately force state IDLE, out_valid=0, busy=0, done=0, gray_out=0, bin_out=0 and clear latched limit/direction, including mid-sequence.
REQ-025 First start after reset release SHALL behave as from power-up.

Configuration
REQ-026 Macro GRAY_SEQ_WRAP_EN: when defined, a terminal beat acceptance in RUN reloads the start value (0 up, limit down) and stays in RUN; only stop leads to FIN.
REQ-027 Without GRAY_SEQ_WRAP_EN, REQ-017 applies and the sequence runs once.

Structure
REQ-028 Shared package gray_seq_pkg SHALL hold the state enum and default WIDTH constant.
REQ-029 Conversion SHALL live in sub-module gray_encode (parameterised WIDTH, combinational XOR), instantiated once ahead of the gray_out register.

Verification
REQ-030 WIDTH=4, limit=7, up, out_ready=1 -> gray 0000,0001,0011,0010,0110,0111,0101,0100 on 8 consecutive cycles, done pulse on cycle 9.
REQ-031 limit=3, down, out_ready=1 -> bin 3,2,1,0 / gray 0010,0011,0001,0000, then done.
REQ-032 limit=5, out_ready low for 3 cycles at bin=2 -> gray_out held at 0011 for all stalled cycles, no code skipped or repeated.
REQ-033 limit=15, stop at bin=4 -> out_valid low next cycle, done pulse, IDLE; a new start restarts at 0000.
REQ-034 rst_n low at bin=6 -> all outputs 0 immediately; start after release begins at 0000.
REQ-035 GRAY_SEQ_WRAP_EN, limit=2, up -> gray 00,01,11,00,01,... until stop, then done.
